// File: rtl/super_stop_watch_ctrl.sv
// ---------------------------------------------------------------------------
// super_stop_watch_ctrl
//   Run/pause/clear controller and BCD time-counter chain for the eight-digit
//   stopwatch (HH MM SS hh). Prescales i_clk to a 10 ms tick, sequences
//   counting with a small FSM and drives digit nibbles d7..d0 to the two
//   four-digit scan displays (d3..d0 -> display 0, d7..d4 -> display 1).
//
// Parameters
//   TICK_DIV      clock cycles per 10 ms tick (>= 2)
//
// Ports
//   i_clk         system clock, rising edge
//   i_reset       asynchronous, active-high reset
//   i_start_stop  debounced level; rising edge toggles run/pause
//   i_clr         debounced level; high forces IDLE and zeroes digits
//   i_lap         debounced level; rising edge toggles lap freeze
//   o_d7..o_d0    BCD digits (hours, minutes, seconds, hundredths)
//   o_running     high in RUN
//   o_ovf         high in FULL (saturated at 99:59:59.99)
//   o_lap_active  high while displayed digits are frozen
//
// Build option
//   STOP_WATCH_LAP_EN  when defined, adds the lap-freeze snapshot; otherwise
//                      i_lap is ignored and o_lap_active is tied low.
//
// state   | meaning
// S_IDLE  | cleared, digits zero, prescaler zero
// S_RUN   | prescaler running, chain increments on tick
// S_PAUSE | prescaler and digits held
// S_FULL  | saturated at 99:59:59.99, only clr exits
// ---------------------------------------------------------------------------
module super_stop_watch_ctrl #(
  parameter int TICK_DIV = 1000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start_stop,
  input  logic       i_clr,
  input  logic       i_lap,
  output logic [3:0] o_d7,
  output logic [3:0] o_d6,
  output logic [3:0] o_d5,
  output logic [3:0] o_d4,
  output logic [3:0] o_d3,
  output logic [3:0] o_d2,
  output logic [3:0] o_d1,
  output logic [3:0] o_d0,
  output logic       o_running,
  output logic       o_ovf,
  output logic       o_lap_active
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_FULL} state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
  // Wrap value of each digit, index 0 = hundredths units.
  localparam logic [7:0][3:0] DIG_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  state_t           r_state, w_next;
  logic [PW-1:0]    r_presc;
  logic [7:0][3:0]  r_dig;
  logic [7:0][3:0]  w_dig_inc;
  logic [7:0][3:0]  w_disp;
  logic             r_ss_prev, r_lap_prev;
  logic             w_ss_edge, w_tick, w_sat;

  assign w_ss_edge = i_start_stop & ~r_ss_prev;
  assign w_tick    = (r_state == S_RUN) && (r_presc == PRESC_TC);

  // Ripple increment: a digit advances only when every lower digit wraps.
  // w_sat flags that all digits sit at their maximum (99:59:59.99).
  always_comb begin
    logic carry;
    carry     = 1'b1;
    w_dig_inc = r_dig;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (r_dig[i] == DIG_MAX[i]) begin
          w_dig_inc[i] = 4'd0;
        end else begin
          w_dig_inc[i] = r_dig[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
    w_sat = carry;
  end

  always_comb begin
    w_next = r_state;
    if (i_clr) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_ss_edge) w_next = S_RUN;
        // Saturation wins over a coincident start edge.
        S_RUN:   if (w_tick && w_sat) w_next = S_FULL;
                 else if (w_ss_edge)  w_next = S_PAUSE;
        S_PAUSE: if (w_ss_edge) w_next = S_RUN;
        default: w_next = S_FULL;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      // Prev registers reset high so a button held through reset is no edge.
      r_ss_prev  <= 1'b1;
      r_lap_prev <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_ss_prev  <= i_start_stop;
      r_lap_prev <= i_lap;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
      r_dig   <= '0;
    end else if (i_clr) begin
      r_presc <= '0;
      r_dig   <= '0;
    end else if (r_state == S_RUN) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick && !w_sat) r_dig <= w_dig_inc;
    end else if (r_state == S_IDLE) begin
      r_presc <= '0;
    end
  end

`ifdef STOP_WATCH_LAP_EN
  logic            r_lap_hold;
  logic [7:0][3:0] r_snap;
  logic            w_lap_edge;

  assign w_lap_edge = i_lap & ~r_lap_prev;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lap_hold <= 1'b0;
      r_snap     <= '0;
    end else if (i_clr || (r_state == S_RUN && w_next == S_FULL)) begin
      r_lap_hold <= 1'b0;
    end else if ((r_state == S_RUN || r_state == S_PAUSE) && w_lap_edge) begin
      r_lap_hold <= ~r_lap_hold;
      if (!r_lap_hold) r_snap <= r_dig;
    end
  end

  assign w_disp       = r_lap_hold ? r_snap : r_dig;
  assign o_lap_active = r_lap_hold;
`else
  logic w_lap_unused;
  assign w_lap_unused = r_lap_prev;
  assign w_disp       = r_dig;
  assign o_lap_active = 1'b0;
`endif

  assign o_d0      = w_disp[0];
  assign o_d1      = w_disp[1];
  assign o_d2      = w_disp[2];
  assign o_d3      = w_disp[3];
  assign o_d4      = w_disp[4];
  assign o_d5      = w_disp[5];
  assign o_d6      = w_disp[6];
  assign o_d7      = w_disp[7];
  assign o_running = (r_state == S_RUN);
  assign o_ovf     = (r_state == S_FULL);

endmodule

// File: tb/tb_super_stop_watch_ctrl.sv
// Bench for super_stop_watch_ctrl with TICK_DIV=4. The reference model keeps
// elapsed time as a plain hundredths count and converts to HH MM SS hh with
// division; directed scenarios follow the stopwatch use cases and a random
// phase exercises button/clr/lap interleavings.
module tb_super_stop_watch_ctrl;

  localparam int TD      = 4;
  localparam int CNT_MAX = 99*360000 + 59*6000 + 59*100 + 99;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FULL = 3;

  logic       i_clk, i_reset, i_start_stop, i_clr, i_lap;
  logic [3:0] o_d7, o_d6, o_d5, o_d4, o_d3, o_d2, o_d1, o_d0;
  logic       o_running, o_ovf, o_lap_active;

  super_stop_watch_ctrl #(.TICK_DIV(TD)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start_stop(i_start_stop),
    .i_clr(i_clr), .i_lap(i_lap),
    .o_d7(o_d7), .o_d6(o_d6), .o_d5(o_d5), .o_d4(o_d4),
    .o_d3(o_d3), .o_d2(o_d2), .o_d1(o_d1), .o_d0(o_d0),
    .o_running(o_running), .o_ovf(o_ovf), .o_lap_active(o_lap_active)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_bad = 0;

  // reference model
  int m_mode, m_cnt, m_presc, m_snap;
  bit m_ss_prev, m_lap_prev, m_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int c);
    int hh, s, m, h;
    hh = c % 100;
    s  = (c / 100) % 60;
    m  = (c / 6000) % 60;
    h  = c / 360000;
    return {4'(h/10), 4'(h%10), 4'(m/10), 4'(m%10),
            4'(s/10), 4'(s%10), 4'(hh/10), 4'(hh%10)};
  endfunction

  function automatic logic [31:0] disp();
    return {o_d7, o_d6, o_d5, o_d4, o_d3, o_d2, o_d1, o_d0};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_presc = 0; m_snap = 0; m_hold = 0;
    m_ss_prev = 1; m_lap_prev = 1;
  endtask

  task automatic model_step();
    bit ss_e, lap_e, lap_ok, went_full;
    int old_cnt;
    ss_e  = i_start_stop && !m_ss_prev;
    lap_e = i_lap && !m_lap_prev;
    m_ss_prev  = i_start_stop;
    m_lap_prev = i_lap;
    old_cnt    = m_cnt;
    went_full  = 0;
    lap_ok     = (m_mode == M_RUN || m_mode == M_PAUSE) && lap_e;
    if (i_clr) begin
      m_mode = M_IDLE; m_cnt = 0; m_presc = 0; m_hold = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        m_presc = 0;
        if (ss_e) m_mode = M_RUN;
      end
      M_RUN: begin
        if (m_presc == TD-1) begin
          m_presc = 0;
          if (m_cnt == CNT_MAX) begin m_mode = M_FULL; went_full = 1; end
          else m_cnt++;
        end else begin
          m_presc++;
        end
        if (!went_full && ss_e) m_mode = M_PAUSE;
      end
      M_PAUSE: if (ss_e) m_mode = M_RUN;
      default: ;
    endcase
`ifdef STOP_WATCH_LAP_EN
    if (went_full) m_hold = 0;
    else if (lap_ok) begin
      if (!m_hold) m_snap = old_cnt;
      m_hold = !m_hold;
    end
`else
    if (lap_ok) m_hold = m_hold;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_dig"}, disp(), to_bcd(m_hold ? m_snap : m_cnt));
    chk({tag, "_run"}, 32'(o_running), 32'(m_mode == M_RUN));
    chk({tag, "_ovf"}, 32'(o_ovf), 32'(m_mode == M_FULL));
    chk({tag, "_lap"}, 32'(o_lap_active), 32'(m_hold));
  endtask

  task automatic cyc(input string tag = "cyc");
    @(posedge i_clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic pulse_ss();
    i_start_stop = 1; cyc("ss"); i_start_stop = 0;
  endtask

  task automatic preload(input int v);
    dut.r_dig = to_bcd(v);
    m_cnt = v;
  endtask

  initial begin
    i_reset = 1; i_start_stop = 0; i_clr = 0; i_lap = 0;
    model_reset();
    #3;
    check_all("rst");
    @(negedge i_clk);
    i_reset = 0;
    repeat (3) cyc("idle");

    // count from zero: 40 cycles after the start edge gives .10
    pulse_ss();
    repeat (40) cyc("s1");
    chk("s1_running", 32'(o_running), 32'd1);
    chk("s1_d1", 32'(o_d1), 32'd1);
    chk("s1_d0", 32'(o_d0), 32'd0);

    // hundredths -> seconds carry, then seconds -> minutes carry
    for (int k = 0; k < 1000 && m_cnt < 100; k++) cyc("s2a");
    chk("s2_sec_carry", disp(), 32'h0000_0100);
    preload(5999);
    for (int k = 0; k < 20 && m_cnt < 6000; k++) cyc("s2b");
    chk("s2_min_carry", disp(), 32'h0001_0000);

    // pause with partial prescale, hold, resume latency
    i_clr = 1; cyc("clr"); i_clr = 0;
    pulse_ss();
    for (int k = 0; k < 100 && !(m_cnt == 5 && m_presc == 1); k++) cyc("s3a");
    pulse_ss();
    chk("s3_paused", 32'(o_running), 32'd0);
    repeat (100) cyc("s3hold");
    chk("s3_hold_dig", disp(), 32'h0000_0005);
    pulse_ss();
    chk("s3_resumed", 32'(o_running), 32'd1);
    cyc("s3r1");
    chk("s3_no_inc_yet", disp(), 32'h0000_0005);
    cyc("s3r2");
    chk("s3_inc_after2", disp(), 32'h0000_0006);

    // saturation at 99:59:59.99
    preload(CNT_MAX);
    for (int k = 0; k < 10 && m_mode != M_FULL; k++) cyc("s4a");
    chk("s4_sat_dig", disp(), 32'h9959_5999);
    chk("s4_ovf", 32'(o_ovf), 32'd1);
    chk("s4_run", 32'(o_running), 32'd0);
    pulse_ss();
    repeat (8) cyc("s4b");
    chk("s4_full_ignore", disp(), 32'h9959_5999);
    chk("s4_full_stay", 32'(o_ovf), 32'd1);
    i_clr = 1; cyc("s4clr"); i_clr = 0;
    chk("s4_clr_dig", disp(), 32'd0);
    chk("s4_clr_ovf", 32'(o_ovf), 32'd0);

    // clr beats a simultaneous start edge
    pulse_ss();
    repeat (10) cyc("s5a");
    i_clr = 1; i_start_stop = 1; cyc("s5"); i_clr = 0; i_start_stop = 0;
    chk("s5_run", 32'(o_running), 32'd0);
    chk("s5_dig", disp(), 32'd0);
    cyc("s5b");

    // lap freeze
    pulse_ss();
    for (int k = 0; k < 200 && m_cnt < 20; k++) cyc("s6a");
    i_lap = 1; cyc("s6lap"); i_lap = 0;
    repeat (19) cyc("s6b");
`ifdef STOP_WATCH_LAP_EN
    chk("s6_frozen", disp(), 32'h0000_0020);
    chk("s6_lap_on", 32'(o_lap_active), 32'd1);
`else
    chk("s6_lap_ignored", 32'(o_lap_active), 32'd0);
`endif
    i_lap = 1; cyc("s6lap2"); i_lap = 0;
    chk("s6_release_dig", disp(), 32'h0000_0025);
    chk("s6_lap_off", 32'(o_lap_active), 32'd0);

    // random interleavings of buttons, clr, lap and boundary preloads
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) i_start_stop = ~i_start_stop;
      if ($urandom_range(0, 14) == 0) i_lap = ~i_lap;
      i_clr = ($urandom_range(0, 149) == 0);
      cyc("rnd");
      if (m_mode != M_FULL && $urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 2))
          0: preload(CNT_MAX - int'($urandom_range(0, 30)));
          1: preload(359999 - int'($urandom_range(0, 10)));
          default: preload(int'($urandom_range(0, CNT_MAX)));
        endcase
      end
    end
    i_clr = 0; i_start_stop = 0; i_lap = 0;

    // asynchronous reset mid-count
    i_clr = 1; cyc("pre_rst"); i_clr = 0;
    pulse_ss();
    repeat (30) cyc("pre_rst");
    #2;
    i_reset = 1;
    #1;
    model_reset();
    chk("arst_dig", disp(), 32'd0);
    chk("arst_run", 32'(o_running), 32'd0);
    chk("arst_ovf", 32'(o_ovf), 32'd0);
    chk("arst_lap", 32'(o_lap_active), 32'd0);
    @(negedge i_clk);
    i_reset = 0;
    repeat (5) cyc("post_rst");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
